// File: rtl/gate_product_sequencer_pkg.sv
// gate_product_sequencer_pkg
// Types and constants shared by the gate product sequencer, the 2x2
// fixed-point matrix multiplier and the blocks that call them.
//   WIDTH     : matrix element width, two's-complement fixed point
//   FRAC_BITS : fractional bits; 1.0 is 1 << FRAC_BITS
//   COUNT_W   : width of the gates-multiplied counter
//   elem_t    : one matrix element
//   mtx_t     : 2x2 matrix, indexed [row][col]
//   IDENTITY  : 2x2 identity in this fixed-point format
//   state_t   : sequencer states
package gate_product_sequencer_pkg;

  localparam int WIDTH     = 19;
  localparam int FRAC_BITS = 16;
  localparam int COUNT_W   = 8;

  typedef logic signed [WIDTH-1:0] elem_t;
  typedef elem_t [0:1][0:1]        mtx_t;

  localparam elem_t FX_ONE  = elem_t'(1 << FRAC_BITS);
  localparam elem_t FX_ZERO = '0;

  // Packed [0:1][0:1] puts [0][0] in the most significant slot, so the
  // concatenation reads row-major: {m00, m01, m10, m11}.
  localparam mtx_t IDENTITY = {FX_ONE, FX_ZERO, FX_ZERO, FX_ONE};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_MUL   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/gate_product_sequencer_if.sv
// gate_product_sequencer_if
// Bundles every non-clock/reset signal of the gate product sequencer.
//   master modport : the sequencer itself
//   slave modport  : its surroundings (gate front end, multiplier, consumer)
// Signals:
//   start                         one-cycle pulse, begin a new product
//   gate_valid/gate_ready         gate stream handshake
//   gate_mtx, gate_last           gate matrix and end-of-sequence flag
//   mul_a, mul_b                  multiplier operands (gate, accumulator)
//   mul_ready                     level request to the multiplier
//   mul_completed, mul_r          multiplier completion and result
//   result_mtx/result_valid/ready final product handshake
//   gate_count                    gates multiplied since start (saturating)
//   busy                          sequencer not idle
interface gate_product_sequencer_if
  import gate_product_sequencer_pkg::*;
();

  logic               start;
  logic               gate_valid;
  logic               gate_ready;
  mtx_t               gate_mtx;
  logic               gate_last;
  mtx_t               mul_a;
  mtx_t               mul_b;
  logic               mul_ready;
  logic               mul_completed;
  mtx_t               mul_r;
  mtx_t               result_mtx;
  logic               result_valid;
  logic               result_ready;
  logic [COUNT_W-1:0] gate_count;
  logic               busy;

  modport master (
    input  start, gate_valid, gate_mtx, gate_last, mul_completed, mul_r,
           result_ready,
    output gate_ready, mul_a, mul_b, mul_ready, result_mtx, result_valid,
           gate_count, busy
  );

  modport slave (
    output start, gate_valid, gate_mtx, gate_last, mul_completed, mul_r,
           result_ready,
    input  gate_ready, mul_a, mul_b, mul_ready, result_mtx, result_valid,
           gate_count, busy
  );

endinterface

// File: rtl/gate_product_sequencer.sv
// gate_product_sequencer
// Accumulates U = G_n * ... * G_1 (starting from identity) by feeding each
// incoming gate and the running accumulator to an external 2x2 multiplier,
// one handshake per gate, then offers U on a valid/ready result port.
// Ports:
//   i_clk    clock, rising edge
//   i_reset  asynchronous active-low reset
//   bus      gate_product_sequencer_if.master (gate stream, multiplier
//            handshake, result port, gate_count, busy)
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for start; gate traffic ignored
// ST_LOAD  | gate_ready high, waiting for a gate
// ST_MUL   | mul_ready high, operands frozen until mul_completed
// ST_DRAIN | mul_ready low, waiting for mul_completed to fall
// ST_DONE  | result_valid high until result_ready
module gate_product_sequencer
  import gate_product_sequencer_pkg::*;
(
  input logic                      i_clk,
  input logic                      i_reset,
  gate_product_sequencer_if.master bus
);

  state_t             r_state;
  state_t             w_state_nxt;
  mtx_t               r_acc;
  mtx_t               r_mul_a;
  mtx_t               r_result;
  logic               r_last;
  logic [COUNT_W-1:0] r_count;
  logic               r_gate_ready;
  logic               r_mul_ready;
  logic               r_result_valid;
  logic               r_busy;

  logic w_gate_ready_nxt;
  logic w_mul_ready_nxt;
  logic w_result_valid_nxt;
  logic w_busy_nxt;

  logic w_start;
  logic w_accept;
  logic w_capture;
  logic w_enter_done;

  assign w_start      = (r_state == ST_IDLE) && bus.start;
  assign w_accept     = r_gate_ready && bus.gate_valid;
  assign w_capture    = r_mul_ready && bus.mul_completed;
  // Completed trails ready in the multiplier, so a new gate (or the result)
  // is only released once the previous completed pulse has been seen low.
  assign w_enter_done = (r_state == ST_DRAIN) && !bus.mul_completed && r_last;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (bus.start)          w_state_nxt = ST_LOAD;
      ST_LOAD:  if (w_accept)           w_state_nxt = ST_MUL;
      ST_MUL:   if (bus.mul_completed)  w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (!bus.mul_completed) w_state_nxt = r_last ? ST_DONE : ST_LOAD;
      ST_DONE:  if (bus.result_ready)   w_state_nxt = ST_IDLE;
      default:                          w_state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs are decoded from the next state and registered, so
  // they change exactly on the edge that enters or leaves a state.
  always_comb begin
    w_gate_ready_nxt   = (w_state_nxt == ST_LOAD);
    w_mul_ready_nxt    = (w_state_nxt == ST_MUL);
    w_result_valid_nxt = (w_state_nxt == ST_DONE);
    w_busy_nxt         = (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_gate_ready   <= 1'b0;
      r_mul_ready    <= 1'b0;
      r_result_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_acc          <= IDENTITY;
      r_mul_a        <= '0;
      r_last         <= 1'b0;
      r_count        <= '0;
      r_result       <= '0;
    end else begin
      r_gate_ready   <= w_gate_ready_nxt;
      r_mul_ready    <= w_mul_ready_nxt;
      r_result_valid <= w_result_valid_nxt;
      r_busy         <= w_busy_nxt;
      if (w_start) begin
        r_acc   <= IDENTITY;
        r_count <= '0;
      end
      if (w_accept) begin
        r_mul_a <= bus.gate_mtx;
        r_last  <= bus.gate_last;
      end
      if (w_capture) begin
        r_acc <= bus.mul_r;
        if (r_count != '1) begin
          r_count <= r_count + COUNT_W'(1);
        end
      end
      if (w_enter_done) begin
        r_result <= r_acc;
      end
    end
  end

  assign bus.gate_ready   = r_gate_ready;
  assign bus.mul_a        = r_mul_a;
  assign bus.mul_b        = r_acc;
  assign bus.mul_ready    = r_mul_ready;
  assign bus.result_mtx   = r_result;
  assign bus.result_valid = r_result_valid;
  assign bus.gate_count   = r_count;
  assign bus.busy         = r_busy;

endmodule

// File: tb/tb_gate_product_sequencer.sv
module tb_gate_product_sequencer;
  import gate_product_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gate_product_sequencer_if bus();

  gate_product_sequencer dut (
    .i_clk  (clk),
    .i_reset(rst_n),
    .bus    (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    mtx_t               m;
    logic [COUNT_W-1:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  mtx_t gates_q[$];

  // Fixed-point 2x2 product: each element is the exact dot product shifted
  // right by FRAC_BITS and wrapped to WIDTH bits.
  function automatic mtx_t mm(input mtx_t a, input mtx_t b);
    mtx_t   r;
    longint s;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        s = longint'($signed(a[i][0])) * longint'($signed(b[0][j]))
          + longint'($signed(a[i][1])) * longint'($signed(b[1][j]));
        s = s >>> FRAC_BITS;
        r[i][j] = s[WIDTH-1:0];
      end
    end
    return r;
  endfunction

  function automatic elem_t rand_elem();
    int v;
    v = int'($urandom_range(0, 131072)) - 65536;
    return elem_t'(v);
  endfunction

  function automatic mtx_t rand_mtx();
    mtx_t m;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        m[i][j] = rand_elem();
    return m;
  endfunction

  function automatic mtx_t diag(input int d0, input int d1);
    mtx_t m;
    m = '0;
    m[0][0] = elem_t'(d0);
    m[1][1] = elem_t'(d1);
    return m;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Multiplier model: two register stages, completed trails ready by 2.
  logic m_c1;
  mtx_t m_stage;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_c1              <= 1'b0;
      m_stage           <= '0;
      bus.mul_completed <= 1'b0;
      bus.mul_r         <= '0;
    end else begin
      m_c1              <= bus.mul_ready;
      bus.mul_completed <= m_c1;
      m_stage           <= mm(bus.mul_a, bus.mul_b);
      bus.mul_r         <= m_stage;
    end
  end

  // Monitor: protocol invariants and scoreboard pop on result transfer.
  mtx_t prev_a, prev_b;
  logic prev_rdy = 1'b0;
  logic pending  = 1'b0;
  exp_t e_mon;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mul_ready && prev_rdy) begin
        check("mul_a_stable", bus.mul_a, prev_a);
        check("mul_b_stable", bus.mul_b, prev_b);
      end
      prev_rdy = bus.mul_ready;
      prev_a   = bus.mul_a;
      prev_b   = bus.mul_b;
      if (bus.gate_ready)
        check("gate_ready_while_completed", bus.mul_completed, 1'b0);
      if (bus.gate_ready && bus.gate_valid) begin
        check("one_accept_per_product", pending, 1'b0);
        pending = 1'b1;
      end
      if (bus.mul_ready && bus.mul_completed)
        pending = 1'b0;
      if (bus.result_valid && bus.result_ready) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_result: got %h expected none", bus.result_mtx);
        end else begin
          e_mon = sb_q.pop_front();
          check("result_mtx", bus.result_mtx, e_mon.m);
          check("gate_count", bus.gate_count, e_mon.cnt);
        end
      end
    end else begin
      prev_rdy = 1'b0;
      pending  = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed_gate(input mtx_t g, input logic last, input bit keep_valid, output bit ok);
    int t;
    t  = 0;
    ok = 1'b1;
    bus.gate_valid = 1'b1;
    bus.gate_mtx   = g;
    bus.gate_last  = last;
    @(negedge clk);
    while (!bus.gate_ready) begin
      t++;
      if (t > 50) begin
        n_vec++;
        n_err++;
        $display("FAIL gate_accept_timeout: got gate_ready=0 after %0d cycles, required 1", t);
        ok = 1'b0;
        bus.gate_valid = 1'b0;
        tick();
        return;
      end
      @(negedge clk);
    end
    tick();
    if (!keep_valid) bus.gate_valid = 1'b0;
  endtask

  // Runs gates_q as one sequence; the expected product is pushed first.
  task automatic run_seq(input int hold, input bit keep_valid, input bit poke_start,
                         input bit rel_with_start);
    exp_t e;
    mtx_t u;
    int   n;
    int   t;
    bit   ok;
    u = IDENTITY;
    n = gates_q.size();
    foreach (gates_q[i]) u = mm(gates_q[i], u);
    e.m   = u;
    e.cnt = (n > 255) ? '1 : COUNT_W'(n);
    sb_q.push_back(e);

    if (rel_with_start) rst_n = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;

    for (int i = 0; i < n; i++) begin
      if (!keep_valid) repeat ($urandom_range(0, 2)) tick();
      feed_gate(gates_q[i], (i == n - 1), keep_valid, ok);
      if (!ok) begin
        void'(sb_q.pop_back());
        return;
      end
      if (i == 0) begin
        @(negedge clk);
        check("first_mul_a", bus.mul_a, gates_q[0]);
        check("first_mul_b_identity", bus.mul_b, IDENTITY);
        tick();
      end
    end
    bus.gate_valid = 1'b0;
    bus.gate_last  = 1'b0;

    t = 0;
    @(negedge clk);
    while (!bus.result_valid) begin
      t++;
      if (t > 200) begin
        n_vec++;
        n_err++;
        $display("FAIL result_timeout: got result_valid=0, required 1");
        void'(sb_q.pop_back());
        tick();
        return;
      end
      @(negedge clk);
    end

    for (int k = 0; k < hold; k++) begin
      tick();
      bus.start = poke_start && (k == 3);
      @(negedge clk);
      check("done_valid_held", bus.result_valid, 1'b1);
      check("done_mtx_stable", bus.result_mtx, u);
      check("done_gate_ready_low", bus.gate_ready, 1'b0);
    end
    tick();
    bus.start        = 1'b0;
    bus.result_ready = 1'b1;
    tick();
    bus.result_ready = 1'b0;
    @(negedge clk);
    check("valid_low_after_transfer", bus.result_valid, 1'b0);
    check("idle_after_transfer", bus.busy, 1'b0);
    tick();
  endtask

  initial begin
    mtx_t xg, dg;
    bit   ok;
    #300000;
    $display("FAIL watchdog: got no finish, required finish before 300000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    mtx_t xg, dg;
    bit   ok;
    rst_n            = 1'b0;
    bus.start        = 1'b0;
    bus.gate_valid   = 1'b0;
    bus.gate_mtx     = '0;
    bus.gate_last    = 1'b0;
    bus.result_ready = 1'b0;
    repeat (3) tick();

    @(negedge clk);
    check("rst_gate_ready", bus.gate_ready, 1'b0);
    check("rst_mul_ready", bus.mul_ready, 1'b0);
    check("rst_result_valid", bus.result_valid, 1'b0);
    check("rst_gate_count", bus.gate_count, '0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_result_mtx", bus.result_mtx, '0);
    check("rst_mul_a", bus.mul_a, '0);
    check("rst_acc_identity", bus.mul_b, IDENTITY);
    tick();
    rst_n = 1'b1;
    tick();

    // Gate traffic in IDLE is ignored.
    bus.gate_valid = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("idle_ignores_gate", bus.gate_ready, 1'b0);
    check("idle_busy_low", bus.busy, 1'b0);
    tick();
    bus.gate_valid = 1'b0;

    dg = diag(32'h20000, 32'h30000);
    xg = '0;
    xg[0][1] = FX_ONE;
    xg[1][0] = FX_ONE;

    gates_q = '{dg};
    run_seq(0, 1'b0, 1'b0, 1'b0);

    gates_q = '{xg, dg};
    run_seq(1, 1'b0, 1'b0, 1'b0);

    gates_q = '{xg, xg, dg};
    run_seq(0, 1'b1, 1'b0, 1'b0);

    for (int s = 0; s < 20; s++) begin
      gates_q.delete();
      repeat ($urandom_range(1, 6)) gates_q.push_back(rand_mtx());
      run_seq(int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), 1'b0, 1'b0);
    end

    // Result held in DONE for 10 cycles with a start pulse in the middle.
    gates_q = '{rand_mtx(), rand_mtx()};
    run_seq(10, 1'b0, 1'b1, 1'b0);

    // Reset in the middle of the third product.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    feed_gate(xg, 1'b0, 1'b0, ok);
    feed_gate(dg, 1'b0, 1'b0, ok);
    feed_gate(xg, 1'b0, 1'b0, ok);
    @(negedge clk);
    check("pre_reset_mul_ready", bus.mul_ready, 1'b1);
    check("pre_reset_gate_count", bus.gate_count, 8'd2);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_mul_ready", bus.mul_ready, 1'b0);
    check("midrst_result_valid", bus.result_valid, 1'b0);
    check("midrst_gate_count", bus.gate_count, '0);
    check("midrst_busy", bus.busy, 1'b0);
    tick();
    tick();
    // Release reset together with start: start counts on the next edge.
    gates_q = '{dg};
    run_seq(0, 1'b0, 1'b0, 1'b1);

    // Saturation: 300 identity gates, gate_valid held high throughout.
    gates_q.delete();
    repeat (300) gates_q.push_back(IDENTITY);
    run_seq(0, 1'b1, 1'b0, 1'b0);

    repeat (3) tick();
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
